// File: rtl/cpu_pkg.sv
// Constants shared across the CPU front end.
package cpu_pkg;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with a clear port; pointers carry one extra wrap bit to
// distinguish full from empty. DEPTH must be a power of two, >= 2.
module fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic [AW:0]   count
);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         full;
  logic         empty;
  logic         push_ok;
  logic         pop_ok;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch queue: issues credit-limited imem requests, pairs in-order
// responses with their request address, and drops responses orphaned by a flush.
module if_fetch_queue
  import cpu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc,
  output logic             pc_en,
  input  logic             flush,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [WIDTH-1:0] id_pc,
  output logic [WIDTH-1:0] id_inst
);

  localparam int QAW = $clog2(DEPTH);
  localparam int CW  = $clog2(MAX_OUT) + 1;

  logic [QAW:0]         q_cnt;
  logic [CW-1:0]        out_cnt;
  logic [CW-1:0]        drop_cnt;
  logic [WIDTH-1:0]     tag_pc;
  logic [2*WIDTH-1:0]   q_head;
  logic                 rsp_take;
  logic                 q_pop;

  // Drops still occupy the memory pipeline, so they count against MAX_OUT;
  // outstanding requests reserve queue space so a response never overflows it.
  assign imem_req_valid = rst && !flush
                          && (int'(out_cnt) + int'(drop_cnt) < MAX_OUT)
                          && (int'(q_cnt) + int'(out_cnt) < DEPTH);
  assign pc_en     = imem_req_valid && imem_req_ready;
  assign imem_addr = pc;

  assign rsp_take = imem_rsp_valid && (drop_cnt == '0) && !flush;
  assign q_pop    = id_valid && id_ready && !flush;

  // The tag FIFO occupancy is exactly the number of live outstanding requests.
  fetch_fifo #(.W(WIDTH), .DEPTH(MAX_OUT)) u_tag (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (pc_en),
    .push_data (pc),
    .pop       (rsp_take),
    .pop_data  (tag_pc),
    .count     (out_cnt)
  );

  fetch_fifo #(.W(2*WIDTH), .DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (rsp_take),
    .push_data ({tag_pc, imem_rsp_data}),
    .pop       (q_pop),
    .pop_data  (q_head),
    .count     (q_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= '0;
    end else if (flush) begin
      drop_cnt <= drop_cnt + out_cnt - CW'(imem_rsp_valid);
    end else if (imem_rsp_valid && (drop_cnt != '0)) begin
      drop_cnt <= drop_cnt - 1'b1;
    end
  end

  assign id_valid = (q_cnt != '0);
  assign id_pc    = id_valid ? q_head[2*WIDTH-1:WIDTH] : '0;
  assign id_inst  = id_valid ? q_head[WIDTH-1:0]       : '0;

  always @(posedge clk) begin
    if (rst && imem_rsp_valid) assert ((out_cnt != '0) || (drop_cnt != '0));
  end

endmodule

// File: doc/if_fetch_queue.md
IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 32, address/instruction width.
REQ-002 SHALL have parameter DEPTH, default 4, instruction queue entries (power of two, >=2).
REQ-003 SHALL have parameter MAX_OUT, default 2, maximum outstanding imem requests.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port pc  in  WIDTH  current fetch address from PC stage.
REQ-007 SHALL have port pc_en  out  1  advance PC stage (PC loads npc next edge).
REQ-008 SHALL have port flush  in  1  redirect; discard queued and in-flight instructions.
REQ-009 SHALL have port imem_req_valid  out  1  fetch request valid.
REQ-010 SHALL have port imem_req_ready  in  1  imem accepts request.
REQ-011 SHALL have port imem_addr  out  WIDTH  request address (= pc).
REQ-012 SHALL have port imem_rsp_valid  in  1  in-order response valid, >=1 cycle after accept.
REQ-013 SHALL have port imem_rsp_data  in  WIDTH  instruction word.
REQ-014 SHALL have port id_valid  out  1  queue head valid to decode.
REQ-015 SHALL have port id_ready  in  1  decode accepts head.
REQ-016 SHALL have ports id_pc, id_inst  out  WIDTH each  head address and instruction.

Function
REQ-017 SHALL assert imem_req_valid when !flush and out_cnt < MAX_OUT and q_cnt + out_cnt < DEPTH (credit rule; no response ever overflows queue).
REQ-018 SHALL drive pc_en = imem_req_valid & imem_req_ready, combinationally; request accepted exactly when PC advances.
REQ-019 SHALL record the address of each accepted request in an MAX_OUT-deep in-order tag FIFO; pairs with next non-dropped response.
REQ-020 SHALL push {tag pc, imem_rsp_data} into queue on imem_rsp_valid when drop_cnt == 0; zero-latency bypass not required (push visible next cycle).
REQ-021 SHALL pop head on id_valid & id_ready; id_valid = (q_cnt != 0); id_pc/id_inst stable while id_valid & !id_ready.
REQ-022 SHALL support simultaneous push and pop in one cycle, q_cnt unchanged.
REQ-023 SHALL on imem_rsp_valid with drop_cnt > 0 discard the response and decrement drop_cnt.
REQ-024 SHALL on flush: empty queue, clear tag FIFO, set drop_cnt = out_cnt minus 1 if a response arrives that cycle (that response discarded), set out_cnt = 0, suppress request and pop that cycle.
REQ-025 SHALL keep requests blocked while drop_cnt > 0 only if out_cnt + drop_cnt >= MAX_OUT (drops count against MAX_OUT).
REQ-026 SHALL update out_cnt: +1 on accept, -1 on non-dropped response, both in same cycle = unchanged.
REQ-027 SHALL ignore id_ready while queue empty; assertion: imem_rsp_valid never arrives with out_cnt + drop_cnt == 0.
REQ-028 SHALL wrap queue read/write pointers modulo DEPTH using log2(DEPTH)+1-bit pointers for full/empty distinction.

Reset
REQ-029 SHALL on rst low asynchronously clear q_cnt, pointers, out_cnt, drop_cnt, tag FIFO; id_valid=0, imem_req_valid=0, pc_en=0 while rst low.
REQ-030 SHALL discard any response arriving during reset; first request issued first edge after rst deasserts, imem_addr = pc (0x00400000 after PC reset).

Structure
REQ-031 SHALL take RESET_PC (32'h00400000) and NOP_INST (32'h00000013) constants from shared package cpu_pkg.
REQ-032 SHALL instantiate one sub-module fetch_fifo (synchronous parameterised FIFO, flush port) for the instruction queue; tag FIFO may reuse it.
REQ-033 SHALL contain no combinational path from imem_rsp_* to id_*.

Verification
REQ-034 SHALL test: reset, imem always ready, 1-cycle latency, id_ready=1 -> id_pc sequence 0x00400000, 0x00400004, ... one per cycle after 2-cycle fill.
REQ-035 SHALL test: id_ready=0 for 10 cycles -> exactly DEPTH=4 requests issued, pc_en then held 0, queue full, no data lost on release.
REQ-036 SHALL test: flush with 2 outstanding, npc=0x00400100 -> both late responses dropped, next id_pc = 0x00400100.
REQ-037 SHALL test: flush in same cycle as response arrival -> drop_cnt=1, dropped response never reaches id_*.
REQ-038 SHALL test: imem_req_ready toggling 1,0,0,1 -> pc_en mirrors accepts, id_inst order matches address order.
REQ-039 SHALL test: rst asserted mid-stream with 2 outstanding -> all outputs 0 asynchronously, restart from 0x00400000 with no stale instruction.
